tt_scan: RTL and testbench

TT_SCAN -- requirements
Module: tt_scan

---
 rtl/tt_scan.sv | 122 ++++++++++++
 tb/tb_tt_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_scan.sv
// Exhaustive truth-table scanner for a 4-input combinational block: steps {a,b,c,d}
// through 0..15, captures the response per vector and compares it against a latched expectation.
module tt_scan #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_f_in,
    input  logic [15:0] i_expect,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic        o_d,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_table,
    output logic        o_match,
    output logic [3:0]  o_err_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_exp;
    logic [15:0] r_table;
    logic        r_busy;
    logic        r_done;
    logic        r_match;
    logic [3:0]  r_err_idx;

    logic [15:0] w_table_nxt;
    logic [15:0] w_diff;
    logic [3:0]  w_err_idx;
    logic        w_found;

    always_comb begin
        w_table_nxt        = r_table;
        w_table_nxt[r_idx] = i_f_in;
    end

    assign w_diff = w_table_nxt ^ r_exp;

    always_comb begin
        w_err_idx = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (w_diff[i] && !w_found) begin
                w_err_idx = 4'(i);
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_table   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_err_idx <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_HOLD;
                        r_idx   <= '0;
                        r_table <= '0;
                        r_exp   <= i_expect;
                        r_busy  <= 1'b1;
                        r_cnt   <= SETTLE_LD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_SAMPLE;
                    end
                    r_cnt <= r_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    r_table <= w_table_nxt;
                    if (r_idx != 4'd15) begin
                        r_idx   <= r_idx + 4'd1;
                        r_cnt   <= SETTLE_LD;
                        r_state <= S_HOLD;
                    end else begin
                        // Result computed from the final sample so match/err_idx are valid alongside done.
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_match   <= (w_diff == 16'h0000);
                        r_err_idx <= w_err_idx;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign {o_a, o_b, o_c, o_d} = r_idx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_table   = r_table;
    assign o_match   = r_match;
    assign o_err_idx = r_err_idx;

endmodule

// File: tb/tb_tt_scan.sv
// Bench for tt_scan: table-driven full scans plus hand-written sequences for
// stimulus order, back-to-back starts and reset abort.
module tb_tt_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start1, start3;
    logic [15:0] expect1, expect3;
    logic [1:0]  mode1;
    logic        f1, f3;

    logic        a1, b1, c1, d1, busy1, done1, match1;
    logic [15:0] tab1;
    logic [3:0]  err1;
    logic        a3, b3, c3, d3, busy3, done3, match3;
    logic [15:0] tab3;
    logic [3:0]  err3;

    logic [3:0] vec1, vec3;
    assign vec1 = {a1, b1, c1, d1};
    assign vec3 = {a3, b3, c3, d3};

    always_comb begin
        case (mode1)
            2'd0:    f1 = (a1 & b1) | (c1 & ~d1);
            2'd1:    f1 = 1'b0;
            2'd2:    f1 = d1;
            default: f1 = a1;
        endcase
    end
    assign f3 = (a3 & b3) | (c3 & ~d3);

    tt_scan #(.SETTLE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_f_in(f1), .i_expect(expect1),
        .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1), .o_busy(busy1), .o_done(done1),
        .o_table(tab1), .o_match(match1), .o_err_idx(err1)
    );

    tt_scan #(.SETTLE(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_f_in(f3), .i_expect(expect3),
        .o_a(a3), .o_b(b3), .o_c(c3), .o_d(d3), .o_busy(busy3), .o_done(done3),
        .o_table(tab3), .o_match(match3), .o_err_idx(err3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] exp_in;
        logic [15:0] tbl;
        logic        mt;
        logic [3:0]  ei;
    } vec_t;

    vec_t vecs[7];

    // Pulse start on dut1, scramble expect after acceptance, return the cycle done was seen in.
    task automatic run1(input logic [15:0] e, output int cyc);
        @(negedge clk);
        start1  = 1'b1;
        expect1 = e;
        @(posedge clk);
        #1;
        start1  = 1'b0;
        expect1 = ~e;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done1) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;

        vecs[0] = '{2'd0, 16'hF444, 16'hF444, 1'b1, 4'd0};
        vecs[1] = '{2'd0, 16'hF445, 16'hF444, 1'b0, 4'd0};
        vecs[2] = '{2'd0, 16'h7444, 16'hF444, 1'b0, 4'd15};
        vecs[3] = '{2'd1, 16'h0000, 16'h0000, 1'b1, 4'd0};
        vecs[4] = '{2'd2, 16'hAAAA, 16'hAAAA, 1'b1, 4'd0};
        vecs[5] = '{2'd2, 16'hAABA, 16'hAAAA, 1'b0, 4'd4};
        vecs[6] = '{2'd3, 16'hFC00, 16'hFF00, 1'b0, 4'd8};

        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        expect1 = '0; expect3 = '0; mode1 = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_vec", {28'd0, vec1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_table", {16'd0, tab1}, 32'd0);
        chk("rst_match", {31'd0, match1}, 32'd0);
        chk("rst_err", {28'd0, err1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            mode1 = vecs[v].mode;
            run1(vecs[v].exp_in, cyc);
            chk($sformatf("v%0d_done_cycle", v), 32'(cyc), 32'd33);
            chk($sformatf("v%0d_table", v), {16'd0, tab1}, {16'd0, vecs[v].tbl});
            chk($sformatf("v%0d_match", v), {31'd0, match1}, {31'd0, vecs[v].mt});
            chk($sformatf("v%0d_err_idx", v), {28'd0, err1}, {28'd0, vecs[v].ei});
            chk($sformatf("v%0d_busy_in_done", v), {31'd0, busy1}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", v), {31'd0, done1}, 32'd0);
            chk($sformatf("v%0d_busy_idle", v), {31'd0, busy1}, 32'd0);
            chk($sformatf("v%0d_idle_vec", v), {28'd0, vec1}, 32'd15);
            chk($sformatf("v%0d_idle_table", v), {16'd0, tab1}, {16'd0, vecs[v].tbl});
        end

        // SETTLE=3: each vector held 4 cycles, done in cycle 65
        @(negedge clk);
        start3  = 1'b1;
        expect3 = 16'hF444;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            chk($sformatf("s3_vec_c%0d", c), {28'd0, vec3}, 32'((c - 1) / 4));
            if (c == 64) chk("s3_no_early_done", {31'd0, done3}, 32'd0);
        end
        @(negedge clk);
        chk("s3_done_c65", {31'd0, done3}, 32'd1);
        chk("s3_table", {16'd0, tab3}, 32'h0000F444);
        chk("s3_match", {31'd0, match3}, 32'd1);

        // Continuous start: back-to-back scans separated by one IDLE cycle
        mode1 = 2'd0;
        @(negedge clk);
        start1  = 1'b1;
        expect1 = 16'hF444;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            chk($sformatf("cont_done_c%0d", c), {31'd0, done1}, {31'd0, (c % 34) == 33});
            chk($sformatf("cont_busy_c%0d", c), {31'd0, busy1}, {31'd0, (c % 34) != 0});
        end
        start1 = 1'b0;
        cyc = 0;
        while (cyc < 100 && !done1) begin
            @(negedge clk);
            cyc++;
        end
        chk("cont_third_done", {31'd0, done1}, 32'd1);
        @(negedge clk);

        // Abort: reset while vector 7 is applied
        @(negedge clk);
        start1  = 1'b1;
        expect1 = 16'hF444;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = 0;
        while (cyc < 100 && vec1 != 4'd7) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_idx7", {28'd0, vec1}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_vec", {28'd0, vec1}, 32'd0);
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_table", {16'd0, tab1}, 32'd0);
        chk("abort_match", {31'd0, match1}, 32'd0);
        chk("abort_err", {28'd0, err1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        @(negedge clk);
        start1  = 1'b1;
        expect1 = 16'hF444;
        @(posedge clk);
        #1;
        start1  = 1'b0;
        expect1 = 16'h0000;
        @(negedge clk);
        chk("restart_vec_c1", {28'd0, vec1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("restart_vec_c3", {28'd0, vec1}, 32'd1);
        cyc = 3;
        while (cyc < 200 && !done1) begin
            @(negedge clk);
            cyc++;
        end
        chk("restart_done_cycle", 32'(cyc), 32'd33);
        chk("restart_table", {16'd0, tab1}, 32'h0000F444);
        chk("restart_match", {31'd0, match1}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
